// File: rtl/rxll_frame_rd_pkg.sv
// Shared definitions for the receive link-layer frame unloader: FIFO word layout,
// unloader state encoding and well-known FIS type codes.
package rxll_frame_rd_pkg;

   localparam int SOF_BIT = 32;
   localparam int CRC_BIT = 33;
   localparam int EOF_BIT = 34;

   localparam int C_MAX_DW_DFLT = 2049;

   localparam logic [7:0] FIS_D2H_REG   = 8'h34;
   localparam logic [7:0] FIS_DATA      = 8'h46;
   localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HUNT,
      ST_DATA,
      ST_DROP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/rxll_out_reg.sv
// Single-entry valid/ready output register: a load shows up as valid on the next cycle.
// The caller only loads when the entry is empty or draining, so a held word is never overwritten.
module rxll_out_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        load_sof,
   input  logic        load_eof,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] data,
   output logic        sof,
   output logic        eof
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         sof   <= 1'b0;
         eof   <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         sof   <= load_sof;
         eof   <= load_eof;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rxll_frame_rd.sv
// Frame unloader between the receive link-layer FIFO and the transport stream; first dword
// appears one cycle after its pop, and pops stall while the output register is held by fis_ready=0.
module rxll_frame_rd
   import rxll_frame_rd_pkg::*;
#(
   parameter int C_MAX_DW = C_MAX_DW_DFLT,
   parameter int C_LEN_W  = 12
) (
   input  logic               rd_clk,
   input  logic               rst,
   input  logic [35:0]        rd_do,
   input  logic               rd_empty,
   input  logic               rd_almost_empty,
   input  logic               rd_eof_rdy,
   output logic               rd_en,
   output logic [31:0]        fis_data,
   output logic               fis_valid,
   input  logic               fis_ready,
   output logic               fis_sof,
   output logic               fis_eof,
   output logic [7:0]         fis_type,
   output logic [C_LEN_W-1:0] fis_len,
   output logic               fis_done,
   output logic               fis_err_crc,
   output logic               fis_err_len,
   output logic               fis_err_sof
);

   localparam logic [C_LEN_W-1:0] MAX_LEN = C_LEN_W'(C_MAX_DW);

   state_t             state, state_nxt;
   logic [C_LEN_W-1:0] len;
   logic               w_sof, w_crc, w_eof;
   logic               can_pop;
   logic               load, load_sof, load_eof;
   logic               start, inc, clr_err, set_crc, set_len, set_sof;
   logic               unused_rsvd;

   assign w_sof       = rd_do[SOF_BIT];
   assign w_crc       = rd_do[CRC_BIT];
   assign w_eof       = rd_do[EOF_BIT];
   assign unused_rsvd = rd_do[35];
   assign can_pop     = !rd_empty && (!fis_valid || fis_ready);
   assign fis_len     = len;

   always_ff @(posedge rd_clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      load      = 1'b0;
      load_sof  = 1'b0;
      load_eof  = 1'b0;
      start     = 1'b0;
      inc       = 1'b0;
      clr_err   = 1'b0;
      set_crc   = 1'b0;
      set_len   = 1'b0;
      set_sof   = 1'b0;
      fis_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            // Long DATA FIS is cut through before its EOF has arrived.
            if (rd_eof_rdy || !rd_almost_empty) begin
               state_nxt = ST_HUNT;
               clr_err   = 1'b1;
            end
         end
         ST_HUNT: begin
            rd_en = can_pop;
            if (can_pop && w_sof) begin
               load      = 1'b1;
               load_sof  = 1'b1;
               load_eof  = w_eof;
               start     = 1'b1;
               set_crc   = w_eof && w_crc;
               state_nxt = w_eof ? ST_DONE : ST_DATA;
            end
         end
         ST_DATA: begin
            rd_en = can_pop;
            if (can_pop) begin
               inc = 1'b1;
               if (w_sof || len == MAX_LEN) begin
                  set_sof   = w_sof;
                  set_len   = (len == MAX_LEN);
                  set_crc   = w_eof && w_crc;
                  state_nxt = w_eof ? ST_DONE : ST_DROP;
               end else begin
                  load     = 1'b1;
                  load_eof = w_eof;
                  if (w_eof) begin
                     set_crc   = w_crc;
                     state_nxt = ST_DONE;
                  end
               end
            end
         end
         ST_DROP: begin
            // Dropped words never reach the output register, so backpressure is irrelevant.
            rd_en = !rd_empty;
            if (!rd_empty && w_eof) begin
               set_crc   = w_crc;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!fis_valid) begin
               fis_done  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         len         <= '0;
         fis_type    <= '0;
         fis_err_crc <= 1'b0;
         fis_err_len <= 1'b0;
         fis_err_sof <= 1'b0;
      end else begin
         if (start) begin
            fis_type <= rd_do[7:0];
            len      <= C_LEN_W'(1);
         end else if (inc && len != MAX_LEN) begin
            len <= len + 1'b1;
         end
         if (clr_err) begin
            fis_err_crc <= 1'b0;
            fis_err_len <= 1'b0;
            fis_err_sof <= 1'b0;
         end else begin
            if (set_crc) fis_err_crc <= 1'b1;
            if (set_len) fis_err_len <= 1'b1;
            if (set_sof) fis_err_sof <= 1'b1;
         end
      end
   end

   rxll_out_reg u_out_reg (
      .clk       (rd_clk),
      .rst       (rst),
      .load      (load),
      .load_data (rd_do[31:0]),
      .load_sof  (load_sof),
      .load_eof  (load_eof),
      .ready     (fis_ready),
      .valid     (fis_valid),
      .data      (fis_data),
      .sof       (fis_sof),
      .eof       (fis_eof)
   );

endmodule

// File: tb/tb_rxll_frame_rd.sv
// Bench for rxll_frame_rd: queue-based FIFO model, frame-level reference model and scoreboard.
module tb_rxll_frame_rd;
   import rxll_frame_rd_pkg::*;

   localparam int MAXDW = 2049;

   typedef struct packed {
      logic [31:0] d;
      logic        sof;
      logic        eof;
   } xw_t;

   typedef struct packed {
      logic [11:0] len;
      logic [7:0]  typ;
      logic        crc;
      logic        el;
      logic        es;
   } xd_t;

   logic        rd_clk = 1'b0;
   logic        rst = 1'b1;
   logic [35:0] rd_do = '0;
   logic        rd_empty = 1'b1;
   logic        rd_almost_empty = 1'b1;
   logic        rd_eof_rdy = 1'b0;
   logic        rd_en;
   logic [31:0] fis_data;
   logic        fis_valid;
   logic        fis_ready = 1'b1;
   logic        fis_sof, fis_eof;
   logic [7:0]  fis_type;
   logic [11:0] fis_len;
   logic        fis_done, fis_err_crc, fis_err_len, fis_err_sof;

   rxll_frame_rd dut (
      .rd_clk(rd_clk), .rst(rst), .rd_do(rd_do), .rd_empty(rd_empty),
      .rd_almost_empty(rd_almost_empty), .rd_eof_rdy(rd_eof_rdy), .rd_en(rd_en),
      .fis_data(fis_data), .fis_valid(fis_valid), .fis_ready(fis_ready),
      .fis_sof(fis_sof), .fis_eof(fis_eof), .fis_type(fis_type), .fis_len(fis_len),
      .fis_done(fis_done), .fis_err_crc(fis_err_crc), .fis_err_len(fis_err_len),
      .fis_err_sof(fis_err_sof)
   );

   initial forever #5 rd_clk = ~rd_clk;

   logic [35:0] fifo[$];
   logic [35:0] frm[$];
   xw_t         exp_q[$];
   xd_t         done_q[$];
   int n_tests = 0, n_fail = 0;
   int cyc = 0, n_fwd = 0, n_eof = 0, n_pop = 0, done_cnt = 0;
   int sof_cyc = 0, eof_cyc = 0, done_cyc = 0, done_pops = 0;
   bit s_en = 0, s_rst = 1, toggle = 0, nostall = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] mk(input logic eof, input logic crc, input logic sof,
                                      input logic [31:0] d);
      return {1'b0, eof, crc, sof, d};
   endfunction

   // Frame-level reference: walks the word list and records what the stream must carry.
   task automatic model(input logic [35:0] ws[$]);
      bit  in_frm = 0, drop = 0;
      int  n = 0;
      xd_t d = '0;
      foreach (ws[i]) begin
         logic [35:0] w;
         w = ws[i];
         if (!in_frm) begin
            if (w[32]) begin
               in_frm = 1; drop = 0; n = 1; d = '0; d.typ = w[7:0];
               exp_q.push_back({w[31:0], 1'b1, w[34]});
               if (w[34]) begin
                  d.len = 12'd1; d.crc = w[33]; done_q.push_back(d); in_frm = 0;
               end
            end
         end else begin
            if (!drop && !w[32] && n < MAXDW) begin
               n++;
               exp_q.push_back({w[31:0], 1'b0, w[34]});
            end else begin
               if (!drop) begin
                  d.es = w[32];
                  d.el = (n >= MAXDW);
                  if (n < MAXDW) n++;
               end
               drop = 1;
            end
            if (w[34]) begin
               d.len = 12'(n); d.crc = w[33]; done_q.push_back(d); in_frm = 0;
            end
         end
      end
   endtask

   task automatic make_frame(input logic [7:0] typ, input int n, input logic crc_last,
                             input logic [7:0] seed);
      frm.delete();
      for (int i = 0; i < n; i++) begin
         if (i == 0) frm.push_back(mk(n == 1, crc_last && n == 1, 1'b1, {24'h5A5A00 | 24'(seed), typ}));
         else        frm.push_back(mk(i == n - 1, crc_last && i == n - 1, 1'b0,
                                      32'hD000_0000 | (32'(seed) << 16) | 32'(i)));
      end
   endtask

   task automatic send_all();
      model(frm);
      foreach (frm[i]) fifo.push_back(frm[i]);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge rd_clk);
         #1;
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      while (done_cnt < target && budget > 0) begin
         tick();
         budget--;
      end
      chk(name, 64'(done_cnt >= target), 64'd1);
   endtask

   // FIFO model: pop decided by rd_en seen mid-cycle, head re-presented after the edge.
   always @(posedge rd_clk) begin
      #1;
      if (s_rst)     fifo.delete();
      else if (s_en) void'(fifo.pop_front());
      fis_ready = toggle ? !fis_ready : 1'b1;
      #1;
      rd_empty        = (fifo.size() == 0);
      rd_do           = (fifo.size() != 0) ? fifo[0] : '0;
      rd_almost_empty = (fifo.size() < 256);
      rd_eof_rdy      = 1'b0;
      foreach (fifo[i]) if (fifo[i][34]) rd_eof_rdy = 1'b1;
   end

   always @(negedge rd_clk) begin
      xw_t e;
      xd_t d;
      cyc++;
      s_en  = rd_en;
      s_rst = rst;
      if (rst) begin
         exp_q.delete();
         done_q.delete();
      end else begin
         if (rd_empty) chk("pop_while_empty", 64'(rd_en), 64'd0);
         if (nostall && fis_valid && !fis_ready) chk("pop_while_full", 64'(rd_en), 64'd0);
         if (fis_valid && fis_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", 64'(fis_data), 64'hFFFF_FFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("word", {30'd0, fis_data, fis_sof, fis_eof}, {30'd0, e});
            end
            n_fwd++;
            if (fis_sof) sof_cyc = cyc;
            if (fis_eof) begin n_eof++; eof_cyc = cyc; end
         end
         if (fis_done) begin
            if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
               d = done_q.pop_front();
               chk("done_len",  64'(fis_len), 64'(d.len));
               chk("done_type", 64'(fis_type), 64'(d.typ));
               chk("done_errs", {61'd0, fis_err_crc, fis_err_len, fis_err_sof},
                                {61'd0, d.crc, d.el, d.es});
            end
            done_cnt++;
            done_cyc  = cyc;
            done_pops = n_pop;
         end
         if (rd_en) n_pop++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_fwd, base_eof, base_pop, base_done;
      tick(3);
      chk("reset_ctrl", {56'd0, rd_en, fis_valid, fis_sof, fis_eof, fis_done,
                         fis_err_crc, fis_err_len, fis_err_sof}, 64'd0);
      chk("reset_data", {12'd0, fis_data, fis_type, fis_len}, 64'd0);
      rst = 1'b0;
      tick(2);

      // 5-dword D2H register frame, continuous ready
      base_fwd = n_fwd; base_eof = n_eof;
      make_frame(8'h34, 5, 1'b0, 8'h01); send_all();
      wait_done(1, 100, "t1_done");
      chk("t1_len", 64'(fis_len), 64'd5);
      chk("t1_type", 64'(fis_type), 64'h34);
      chk("t1_errs", {61'd0, fis_err_crc, fis_err_len, fis_err_sof}, 64'd0);
      chk("t1_burst", 64'(eof_cyc - sof_cyc), 64'd4);
      chk("t1_done_lag", 64'(done_cyc - eof_cyc), 64'd1);
      chk("t1_count", 64'(n_fwd - base_fwd), 64'd5);
      chk("t1_eofs", 64'(n_eof - base_eof), 64'd1);

      // Same frame with ready toggling
      toggle = 1; nostall = 1;
      make_frame(8'h34, 5, 1'b0, 8'h02); send_all();
      wait_done(2, 200, "t2_done");
      toggle = 0; nostall = 0;
      chk("t2_len", 64'(fis_len), 64'd5);
      chk("t2_drained", 64'(exp_q.size()), 64'd0);
      tick(2);

      // Garbage then a 2-dword frame
      base_fwd = n_fwd; base_pop = n_pop;
      frm.delete();
      for (int i = 0; i < 3; i++) frm.push_back(mk(1'b0, 1'b0, 1'b0, 32'hBAD0_0000 + 32'(i)));
      fifo.push_back(frm[0]); fifo.push_back(frm[1]); fifo.push_back(frm[2]);
      make_frame(8'h46, 2, 1'b0, 8'h03); send_all();
      wait_done(3, 100, "t3_done");
      chk("t3_len", 64'(fis_len), 64'd2);
      chk("t3_count", 64'(n_fwd - base_fwd), 64'd2);
      chk("t3_pops", 64'(n_pop - base_pop), 64'd5);
      tick(2);

      // One-dword PIO setup frame
      base_eof = n_eof;
      make_frame(8'h5F, 1, 1'b0, 8'h04); send_all();
      wait_done(4, 100, "t4_done");
      chk("t4_len", 64'(fis_len), 64'd1);
      chk("t4_type", 64'(fis_type), 64'h5F);
      chk("t4_eofs", 64'(n_eof - base_eof), 64'd1);
      tick(2);

      // 2100-dword DATA FIS, started by cut-through before EOF is resident
      base_fwd = n_fwd; base_eof = n_eof; base_pop = n_pop;
      make_frame(8'h46, 2100, 1'b0, 8'h05);
      model(frm);
      for (int i = 0; i < 300; i++) fifo.push_back(frm[i]);
      for (int i = 300; i < 2100; i++) begin
         fifo.push_back(frm[i]);
         tick();
      end
      wait_done(5, 3000, "t5_done");
      chk("t5_len", 64'(fis_len), 64'd2049);
      chk("t5_err_len", 64'(fis_err_len), 64'd1);
      chk("t5_count", 64'(n_fwd - base_fwd), 64'd2049);
      chk("t5_eofs", 64'(n_eof - base_eof), 64'd0);
      chk("t5_pops", 64'(done_pops - base_pop), 64'd2100);
      tick(2);

      // CRC flag on the EOF word
      base_eof = n_eof;
      make_frame(8'h34, 4, 1'b1, 8'h06); send_all();
      wait_done(6, 100, "t6_done");
      chk("t6_crc", 64'(fis_err_crc), 64'd1);
      chk("t6_eofs", 64'(n_eof - base_eof), 64'd1);
      tick(2);

      // Reset during word 3 of a 10-dword frame
      base_fwd = n_fwd; base_done = done_cnt;
      make_frame(8'h46, 10, 1'b0, 8'h07); send_all();
      begin
         int budget = 100;
         while (n_fwd - base_fwd < 2 && budget > 0) begin tick(); budget--; end
      end
      rst = 1'b1;
      tick();
      chk("t7_ctrl", {56'd0, rd_en, fis_valid, fis_sof, fis_eof, fis_done,
                      fis_err_crc, fis_err_len, fis_err_sof}, 64'd0);
      chk("t7_data", {12'd0, fis_data, fis_type, fis_len}, 64'd0);
      chk("t7_state", 64'(dut.state), 64'(ST_IDLE));
      rst = 1'b0;
      tick(20);
      chk("t7_no_done", 64'(done_cnt - base_done), 64'd0);

      chk("left_words", 64'(exp_q.size()), 64'd0);
      chk("left_done", 64'(done_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rxll_frame_rd.md
Name: rxll_frame_rd

Overview:
- Read-side frame unloader on rd_clk, directly downstream of the receive link-layer FIFO (36-bit FWFT words: [31:0] dword, [32] SOF, [33] CRC error, [34] EOF, [35] reserved).
- Pops FIFO words, delimits frames, captures FIS type and length, checks framing, and presents dwords to the transport layer on a valid/ready stream.
- Ends each frame with a status pulse.

Parameters:
- C_MAX_DW, 2049, maximum dwords per frame (1 header + 2048 data).
- C_LEN_W, 12, width of the dword length counter; must hold C_MAX_DW.

Ports:
- rd_clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_do  in  36  FIFO head word (FWFT)
- rd_empty  in  1  FIFO empty
- rd_almost_empty  in  1  FIFO holds fewer than 256 words
- rd_eof_rdy  in  1  at least one complete frame resident in FIFO
- rd_en  out  1  pop FIFO head
- fis_data  out  32  dword to transport
- fis_valid  out  1  fis_data valid
- fis_ready  in  1  transport accepts
- fis_sof  out  1  first dword of frame
- fis_eof  out  1  last dword of a well-formed frame
- fis_type  out  8  header dword [7:0], latched at SOF
- fis_len  out  C_LEN_W  dwords forwarded in the current/last frame
- fis_done  out  1  one-cycle end-of-frame status strobe
- fis_err_crc  out  1  frame ended with CRC flag; valid with fis_done
- fis_err_len  out  1  frame exceeded C_MAX_DW; valid with fis_done
- fis_err_sof  out  1  SOF seen inside a frame; valid with fis_done

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Output register empty.
  - Reset mid-frame discards the partial frame with no fis_done.
  - FIFO contents are reset by the same rst upstream.
- Pop rule: rd_en = !rd_empty && state in {HUNT, DATA, DROP} && (state==DROP || !fis_valid || fis_ready). rd_en is never asserted while rd_empty.
- Output stage: single register. A popped word loads fis_data/fis_sof/fis_eof and sets fis_valid on the next edge. The first word appears 1 cycle after its pop. fis_valid clears on fis_ready when no new load. Pop and drain in the same cycle sustain 1 word/cycle.
- IDLE: go to HUNT when rd_eof_rdy=1 or rd_almost_empty=0 (cut-through for long DATA FIS).
- HUNT:
  - Words with [32]=0 are popped and discarded silently.
  - A word with [32]=1 is forwarded with fis_sof=1; fis_type<=rd_do[7:0]; len<=1.
  - If that same word has [34]=1, it is a one-dword frame: go to DONE. Otherwise go to DATA.
- DATA, on each pop:
  - len+1.
  - [34]=1: forward with fis_eof=1, record [33], go to DONE.
  - [32]=1: set err_sof, do not forward, go to DROP.
  - len would exceed C_MAX_DW: set err_len, do not forward, go to DROP.
- DROP: pop and discard until a word with [34]=1, recording its [33], then go to DONE. fis_eof is not issued for dropped frames.
- DONE:
  - Wait until the output register is empty (last word accepted).
  - Pulse fis_done for 1 cycle with fis_len and the error flags, then return to IDLE.
  - Error flags clear on entry to HUNT.
- fis_len saturates at C_MAX_DW.
- fis_type and fis_len hold until the next SOF.
- An empty FIFO mid-frame stalls in place; there is no timeout.

Decomposition:
- Shared package holds:
  - FIFO word bit indices: SOF=32, CRC=33, EOF=34.
  - State encodings: IDLE, HUNT, DATA, DROP, DONE.
  - C_MAX_DW default.
  - FIS type constants: 0x34 D2H reg, 0x46 DATA, 0x5F PIO setup.
- One natural sub-module: rxll_out_reg, the single-entry valid/ready output register.

Test Plan:
- 5-dword frame, type 0x34, fis_ready=1, rd_eof_rdy=1:
  - fis_valid for 5 consecutive cycles, sof on word 1, eof on word 5.
  - fis_done 1 cycle later with fis_len=5, fis_type=0x34, no errors.
- Same frame with fis_ready toggling 1/0: no word lost or duplicated, order preserved, rd_en never asserted when the output register is full and fis_ready=0.
- 3 garbage words (no SOF), then a 2-dword frame: garbage popped, nothing forwarded, fis_len=2.
- 2100-dword DATA FIS (type 0x46) via cut-through (rd_almost_empty=0):
  - 2049 words forwarded, no fis_eof.
  - fis_done with fis_err_len=1, fis_len=2049, after all 2100 words are popped.
- Frame whose EOF word has [33]=1: fis_eof on that word, fis_done with fis_err_crc=1.
- Assert rst during word 3 of a 10-dword frame: all outputs 0 the next cycle, no fis_done, state IDLE.
